fetch_sequencer: RTL and testbench

Control sequencer for the CPU register datapath. It fetches each 16-bit instruction over the 8-bit memory bus in two byte reads, loading the instruction register high byte then low byte. It then hands the instruction to the execute unit and, on completion, updates the program counter and link register for sequential flow, jump, call or return. It drives only the load/increase strobes of those registers; all data paths stay in the datapath.

---
 rtl/cpu_ctrl_pkg.sv | 35 +++
 rtl/fetch_wait_timer.sv | 29 ++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: state encoding, flow-action
// codes and the default memory wait limit.
package cpu_ctrl_pkg;

    localparam int DEFAULT_MEM_WAIT_MAX = 15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_H = 3'd1,
        S_FETCH_L = 3'd2,
        S_ISSUE   = 3'd3,
        S_EXEC    = 3'd4,
        S_HALTED  = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ACT_SEQ  = 3'd0,
        ACT_JUMP = 3'd1,
        ACT_CALL = 3'd2,
        ACT_RET  = 3'd3,
        ACT_HALT = 3'd4
    } flow_act_t;

    // Resolves simultaneous decoder requests: halt > ret > call > jump > sequential.
    function automatic flow_act_t decode_flow(input logic halt_req, input logic ret_req,
                                              input logic call_req, input logic jump_req);
        if (halt_req)      return ACT_HALT;
        else if (ret_req)  return ACT_RET;
        else if (call_req) return ACT_CALL;
        else if (jump_req) return ACT_JUMP;
        else               return ACT_SEQ;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts memory wait cycles of one byte read and flags when the limit is reached.
// A limit of 0 disables the timeout; the counter saturates instead of wrapping.
module fetch_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clock,
    input  logic n_reset,
    input  logic clear,
    input  logic count_en,
    output logic limit
);

    localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] count;

    assign limit = (MEM_WAIT_MAX != 0) && (count == CW'(MEM_WAIT_MAX));

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !limit && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue/retire sequencer: two byte reads into the IR, an
// execute handshake, then PC/link strobes for sequential, jump, call or return flow.
module fetch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = DEFAULT_MEM_WAIT_MAX
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       run,
    input  logic       mem_ready,
    input  logic       exec_done,
    input  logic       halt_req,
    input  logic       ret_req,
    input  logic       call_req,
    input  logic       jump_req,
    output logic       mem_rd,
    output logic       byte_sel,
    output logic       ir_load_H,
    output logic       ir_load_L,
    output logic       exec_start,
    output logic       pc_increase,
    output logic       pc_loadL,
    output logic       pc_loadH,
    output logic       pc_src,
    output logic       link_load,
    output logic       busy,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_dbg
);

    // Memory handshake: mem_rd is a request held for the whole fetch state; a byte
    // transfers on any cycle where mem_rd and mem_ready are both high.

    state_t    state, state_next;
    flow_act_t action;
    logic      timer_clear, timer_en, timer_limit;

    assign state_dbg = state;
    assign action    = decode_flow(halt_req, ret_req, call_req, jump_req);

    fetch_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
        .clock    (clock),
        .n_reset  (n_reset),
        .clear    (timer_clear),
        .count_en (timer_en),
        .limit    (timer_limit)
    );

    always_ff @(posedge clock) begin
        if (!n_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // Outputs are gated by n_reset so nothing strobes in a reset cycle.
    always_comb begin
        state_next  = state;
        timer_en    = 1'b0;
        mem_rd      = 1'b0;
        byte_sel    = 1'b0;
        ir_load_H   = 1'b0;
        ir_load_L   = 1'b0;
        exec_start  = 1'b0;
        pc_increase = 1'b0;
        pc_loadL    = 1'b0;
        pc_loadH    = 1'b0;
        pc_src      = 1'b0;
        link_load   = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        if (n_reset) begin
            case (state)
                S_IDLE: begin
                    if (run) state_next = S_FETCH_H;
                end
                S_FETCH_H: begin
                    busy     = 1'b1;
                    mem_rd   = 1'b1;
                    timer_en = !mem_ready;
                    if (mem_ready) begin
                        ir_load_H  = 1'b1;
                        state_next = S_FETCH_L;
                    end else if (timer_limit) begin
                        state_next = S_FAULT;
                    end
                end
                S_FETCH_L: begin
                    busy     = 1'b1;
                    mem_rd   = 1'b1;
                    byte_sel = 1'b1;
                    timer_en = !mem_ready;
                    if (mem_ready) begin
                        ir_load_L  = 1'b1;
                        state_next = S_ISSUE;
                    end else if (timer_limit) begin
                        state_next = S_FAULT;
                    end
                end
                S_ISSUE: begin
                    busy       = 1'b1;
                    exec_start = 1'b1;
                    state_next = S_EXEC;
                end
                S_EXEC: begin
                    busy = 1'b1;
                    if (exec_done) begin
                        state_next = run ? S_FETCH_H : S_IDLE;
                        case (action)
                            ACT_HALT: begin
                                pc_increase = 1'b1;
                                state_next  = S_HALTED;
                            end
                            ACT_RET: begin
                                pc_loadL = 1'b1;
                                pc_loadH = 1'b1;
                                pc_src   = 1'b1;
                            end
                            ACT_CALL: begin
                                link_load = 1'b1;
                                pc_loadL  = 1'b1;
                                pc_loadH  = 1'b1;
                            end
                            ACT_JUMP: begin
                                pc_loadL = 1'b1;
                                pc_loadH = 1'b1;
                            end
                            default: pc_increase = 1'b1;
                        endcase
                    end
                end
                S_HALTED: halted = 1'b1;
                S_FAULT:  fault  = 1'b1;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // The wait count restarts on every entry into either fetch state.
    assign timer_clear = ((state_next == S_FETCH_H) || (state_next == S_FETCH_L))
                         && (state_next != state);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Cycle-by-cycle directed vectors for fetch_sequencer with MEM_WAIT_MAX=3.
module tb_fetch_sequencer;

    localparam logic [12:0] M_MRD  = 13'h1000;
    localparam logic [12:0] M_BSEL = 13'h0800;
    localparam logic [12:0] M_IRH  = 13'h0400;
    localparam logic [12:0] M_IRL  = 13'h0200;
    localparam logic [12:0] M_XS   = 13'h0100;
    localparam logic [12:0] M_INC  = 13'h0080;
    localparam logic [12:0] M_LDL  = 13'h0040;
    localparam logic [12:0] M_LDH  = 13'h0020;
    localparam logic [12:0] M_SRC  = 13'h0010;
    localparam logic [12:0] M_LNK  = 13'h0008;
    localparam logic [12:0] M_BUSY = 13'h0004;
    localparam logic [12:0] M_HLT  = 13'h0002;
    localparam logic [12:0] M_FLT  = 13'h0001;

    localparam logic [12:0] O_NONE    = 13'h0000;
    localparam logic [12:0] O_FH_WAIT = M_MRD | M_BUSY;
    localparam logic [12:0] O_FH_LOAD = M_MRD | M_IRH | M_BUSY;
    localparam logic [12:0] O_FL_WAIT = M_MRD | M_BSEL | M_BUSY;
    localparam logic [12:0] O_FL_LOAD = M_MRD | M_BSEL | M_IRL | M_BUSY;
    localparam logic [12:0] O_ISSUE   = M_XS | M_BUSY;
    localparam logic [12:0] O_EXWAIT  = M_BUSY;
    localparam logic [12:0] O_SEQ     = M_INC | M_BUSY;
    localparam logic [12:0] O_CALL    = M_LNK | M_LDL | M_LDH | M_BUSY;
    localparam logic [12:0] O_RET     = M_LDL | M_LDH | M_SRC | M_BUSY;

    typedef struct {
        logic       rst_n, run, mrdy, edone, halt, ret, call, jump;
        logic [2:0] st;
        logic [12:0] outs;
    } vec_t;

    logic clock, n_reset, run, mem_ready, exec_done;
    logic halt_req, ret_req, call_req, jump_req;
    logic mem_rd, byte_sel, ir_load_H, ir_load_L, exec_start;
    logic pc_increase, pc_loadL, pc_loadH, pc_src, link_load;
    logic busy, halted, fault;
    logic [2:0] state_dbg;

    vec_t vecs[$];
    logic [15:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    fetch_sequencer #(.MEM_WAIT_MAX(3)) dut (
        .clock(clock), .n_reset(n_reset), .run(run), .mem_ready(mem_ready),
        .exec_done(exec_done), .halt_req(halt_req), .ret_req(ret_req),
        .call_req(call_req), .jump_req(jump_req), .mem_rd(mem_rd), .byte_sel(byte_sel),
        .ir_load_H(ir_load_H), .ir_load_L(ir_load_L), .exec_start(exec_start),
        .pc_increase(pc_increase), .pc_loadL(pc_loadL), .pc_loadH(pc_loadH),
        .pc_src(pc_src), .link_load(link_load), .busy(busy), .halted(halted),
        .fault(fault), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic rn, input logic rr, input logic mr, input logic ed,
                       input logic h, input logic r, input logic c, input logic j,
                       input logic [2:0] st, input logic [12:0] o);
        vec_t v;
        v.rst_n = rn; v.run = rr; v.mrdy = mr; v.edone = ed;
        v.halt = h; v.ret = r; v.call = c; v.jump = j;
        v.st = st; v.outs = o;
        vecs.push_back(v);
    endtask

    // zero-wait FETCH_H, FETCH_L and ISSUE rows
    task automatic add_fetch(input logic rr);
        add(1, rr, 1, 0, 0, 0, 0, 0, 3'd1, O_FH_LOAD);
        add(1, rr, 1, 0, 0, 0, 0, 0, 3'd2, O_FL_LOAD);
        add(1, rr, 1, 0, 0, 0, 0, 0, 3'd3, O_ISSUE);
    endtask

    task automatic drive(input vec_t v);
        n_reset = v.rst_n; run = v.run; mem_ready = v.mrdy; exec_done = v.edone;
        halt_req = v.halt; ret_req = v.ret; call_req = v.call; jump_req = v.jump;
    endtask

    task automatic check(input int idx);
        logic [15:0] got, want;
        got = {state_dbg, mem_rd, byte_sel, ir_load_H, ir_load_L, exec_start,
               pc_increase, pc_loadL, pc_loadH, pc_src, link_load, busy, halted, fault};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL vec%0d {state,outs}: got %0d/%013b required %0d/%013b",
                     idx, got[15:13], got[12:0], want[15:13], want[12:0]);
        end
    endtask

    initial begin
        // reset state and exec_done ignored in IDLE
        add(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, O_NONE);
        add(1, 1, 1, 1, 0, 0, 0, 0, 3'd0, O_NONE);
        // three sequential instructions, 4 cycles each
        for (int k = 0; k < 3; k++) begin
            add_fetch(1);
            add(1, 1, 1, 1, 0, 0, 0, 0, 3'd4, O_SEQ);
        end
        // call+jump after one exec wait cycle
        add_fetch(1);
        add(1, 1, 1, 0, 0, 0, 0, 0, 3'd4, O_EXWAIT);
        add(1, 1, 1, 1, 0, 0, 1, 1, 3'd4, O_CALL);
        // return after one memory wait cycle
        add(1, 1, 0, 0, 0, 0, 0, 0, 3'd1, O_FH_WAIT);
        add_fetch(1);
        add(1, 1, 1, 1, 0, 1, 0, 0, 3'd4, O_RET);
        // run dropped during the instruction, then restarted
        add_fetch(0);
        add(1, 0, 1, 1, 0, 0, 0, 0, 3'd4, O_SEQ);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, O_NONE);
        add(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, O_NONE);
        // halt beats ret; HALTED ignores run/mem_ready until reset
        add_fetch(1);
        add(1, 1, 1, 1, 1, 1, 0, 0, 3'd4, M_INC | M_BUSY);
        add(1, 1, 1, 1, 0, 0, 0, 0, 3'd5, M_HLT);
        add(1, 0, 0, 1, 0, 0, 0, 0, 3'd5, M_HLT);
        add(0, 1, 1, 0, 0, 0, 0, 0, 3'd5, O_NONE);
        add(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, O_NONE);
        // timeout: 4 cycles without mem_ready -> FAULT
        for (int k = 0; k < 4; k++) add(1, 1, 0, 0, 0, 0, 0, 0, 3'd1, O_FH_WAIT);
        add(1, 1, 1, 1, 0, 0, 0, 0, 3'd6, M_FLT);
        add(1, 0, 0, 0, 0, 0, 0, 0, 3'd6, M_FLT);
        add(0, 1, 1, 0, 0, 0, 0, 0, 3'd6, O_NONE);
        add(1, 1, 0, 0, 0, 0, 0, 0, 3'd0, O_NONE);
        // mem_ready in the limit cycle wins, in both halves
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 0, 3'd1, O_FH_WAIT);
        add(1, 1, 1, 0, 0, 0, 0, 0, 3'd1, O_FH_LOAD);
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 0, 0, 0, 3'd2, O_FL_WAIT);
        add(1, 1, 1, 0, 0, 0, 0, 0, 3'd2, O_FL_LOAD);
        add(1, 1, 0, 0, 0, 0, 0, 0, 3'd3, O_ISSUE);
        add(1, 1, 0, 1, 0, 0, 0, 0, 3'd4, O_SEQ);
        // reset mid-FETCH_L with mem_ready: no IR strobe, back to IDLE
        add(1, 1, 1, 0, 0, 0, 0, 0, 3'd1, O_FH_LOAD);
        add(0, 1, 1, 0, 0, 0, 0, 0, 3'd2, O_NONE);
        add(1, 0, 1, 0, 0, 0, 0, 0, 3'd0, O_NONE);

        n_reset = 1'b0; run = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
        halt_req = 1'b0; ret_req = 1'b0; call_req = 1'b0; jump_req = 1'b0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i]);
            exp_q.push_back({vecs[i].st, vecs[i].outs});
            #1;
            check(i);
        end

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
